// File: rtl/multi_mem_responder_if.sv
// Request/response bus between the CPU memory port and multi_mem_responder.
//   master (CPU side)   : drives req, we, addr, wdata; receives rdata, ack, busy
//   slave  (memory side): receives req, we, addr, wdata; drives rdata, ack, busy
// Optional macro MEM_RANGE_ERR_EN adds err (slave -> master), high with ack
// when the accessed word address lies outside the implemented depth.
interface multi_mem_responder_if #(
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned DATA_W = 32;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
`ifdef MEM_RANGE_ERR_EN
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, busy, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy, err);
`else
  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
`endif
endinterface

// File: rtl/multi_mem_responder.sv
// Word-addressed memory responder with a configurable number of wait states.
// Accepts one request at a time over req/ack, holds it for WAIT_CYCLES, then
// performs the access and pulses ack for one cycle with registered read data.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - multi_mem_responder_if.slave (req/we/addr/wdata in; rdata/ack/busy out)
// Parameters: ADDR_W (word-address width), DEPTH (implemented words,
//   <= 2**ADDR_W), WAIT_CYCLES (0..15).
// Optional macro MEM_RANGE_ERR_EN: adds bus.err, high with ack for addr >= DEPTH.
// Out-of-range writes are dropped and out-of-range reads return zero either way.
module multi_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_mem_responder_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
`ifdef MEM_RANGE_ERR_EN
  logic                err_q, err_d;
`endif

  logic                in_range_c;
  logic                mem_wr_c;
  logic [DATA_W-1:0]   rd_word_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Addresses at or above DEPTH have no backing storage.
  assign in_range_c = (32'(addr_q) < DEPTH);
  assign rd_word_c  = mem[IDX_W'(addr_q)];

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    mem_wr_c = 1'b0;
`ifdef MEM_RANGE_ERR_EN
    err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Busy drops the edge after ack unless a back-to-back request lands.
        busy_d = bus.req;
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d   = 1'b1;
        state_d = IDLE;
        if (we_q) begin
          mem_wr_c = in_range_c;
        end else begin
          rdata_d = in_range_c ? rd_word_c : '0;
        end
`ifdef MEM_RANGE_ERR_EN
        err_d = ~in_range_c;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MEM_RANGE_ERR_EN
  // Range error flag, aligned with ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      mem[IDX_W'(addr_q)] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_multi_mem_responder.sv
// Bench for multi_mem_responder: two instances (DEPTH=512/WAIT=2 and
// DEPTH=1024/WAIT=0) share clk/rst. A transaction-level model predicts
// ack/busy/rdata(/err) from acceptance time + latency; directed tests add
// hand-computed latency and data checks.
module tb_multi_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned D0     = 512;
  localparam int unsigned W0     = 2;
  localparam int unsigned D1     = 1024;
  localparam int unsigned W1     = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multi_mem_responder_if #(.ADDR_W(ADDR_W)) bus0 ();
  multi_mem_responder_if #(.ADDR_W(ADDR_W)) bus1 ();

  multi_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  multi_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 32'h%08h, want 32'h%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Flattened views of both buses.
  logic              in_req   [2];
  logic              in_we    [2];
  logic [ADDR_W-1:0] in_addr  [2];
  logic [31:0]       in_wdata [2];
  logic              o_ack    [2];
  logic              o_busy   [2];
  logic              o_err    [2];
  logic [31:0]       o_rdata  [2];

  assign in_req[0]   = bus0.req;
  assign in_we[0]    = bus0.we;
  assign in_addr[0]  = bus0.addr;
  assign in_wdata[0] = bus0.wdata;
  assign in_req[1]   = bus1.req;
  assign in_we[1]    = bus1.we;
  assign in_addr[1]  = bus1.addr;
  assign in_wdata[1] = bus1.wdata;
  assign o_ack[0]    = bus0.ack;
  assign o_busy[0]   = bus0.busy;
  assign o_rdata[0]  = bus0.rdata;
  assign o_ack[1]    = bus1.ack;
  assign o_busy[1]   = bus1.busy;
  assign o_rdata[1]  = bus1.rdata;
`ifdef MEM_RANGE_ERR_EN
  assign o_err[0]    = bus0.err;
  assign o_err[1]    = bus1.err;
`else
  assign o_err[0]    = 1'b0;
  assign o_err[1]    = 1'b0;
`endif

  function automatic int depth_of(input int i);
    return (i == 0) ? int'(D0) : int'(D1);
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? int'(W0) : int'(W1);
  endfunction

  // Transaction model: a request accepted at edge N completes at edge N+W+1.
  bit              m_pend  [2] = '{0, 0};
  int              m_due   [2] = '{0, 0};
  logic            m_we    [2] = '{0, 0};
  logic [ADDR_W-1:0] m_addr[2] = '{'0, '0};
  logic [31:0]     m_wdata [2] = '{'0, '0};
  logic            e_ack   [2] = '{0, 0};
  logic            e_busy  [2] = '{0, 0};
  logic            e_err   [2] = '{0, 0};
  logic [31:0]     e_rdata [2] = '{'0, '0};
  logic [31:0]     m_mem   [int];

  initial begin
    int  edge_n;
    int  key;
    bit  inr;
    edge_n = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          m_pend[i]  = 1'b0;
          e_ack[i]   = 1'b0;
          e_busy[i]  = 1'b0;
          e_err[i]   = 1'b0;
          e_rdata[i] = '0;
        end
      end else begin
        edge_n++;
        for (int i = 0; i < 2; i++) begin
          e_ack[i] = 1'b0;
          e_err[i] = 1'b0;
          if (m_pend[i] && edge_n == m_due[i]) begin
            e_ack[i]  = 1'b1;
            m_pend[i] = 1'b0;
            key = i * 4096 + int'(m_addr[i]);
            inr = int'(m_addr[i]) < depth_of(i);
            e_err[i] = ~inr;
            if (m_we[i]) begin
              if (inr) m_mem[key] = m_wdata[i];
            end else begin
              e_rdata[i] = (inr && m_mem.exists(key)) ? m_mem[key] : 32'd0;
            end
          end else if (!m_pend[i] && in_req[i]) begin
            m_pend[i]  = 1'b1;
            m_we[i]    = in_we[i];
            m_addr[i]  = in_addr[i];
            m_wdata[i] = in_wdata[i];
            m_due[i]   = edge_n + wait_of(i) + 1;
          end
          e_busy[i] = m_pend[i] | e_ack[i];
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_ack%0d", i),   32'(o_ack[i]),  32'(e_ack[i]));
        chk($sformatf("model_busy%0d", i),  32'(o_busy[i]), 32'(e_busy[i]));
        chk($sformatf("model_rdata%0d", i), o_rdata[i],     e_rdata[i]);
`ifdef MEM_RANGE_ERR_EN
        chk($sformatf("model_err%0d", i),   32'(o_err[i]),  32'(e_err[i]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int i, input logic r, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    if (i == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.wdata = d;
    end
  endtask

  // One request pulse; n = edges from acceptance to ack (0 if none within bound).
  task automatic txn(input int i, input logic w, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d, output int n, output logic [31:0] rd,
                     output logic er);
    drive(i, 1'b1, w, a, d);
    tick();
    drive(i, 1'b0, 1'b0, '0, '0);
    n  = 0;
    rd = '0;
    er = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (o_ack[i]) begin
        n  = k;
        rd = o_rdata[i];
        er = o_err[i];
        break;
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] rd;
    logic        er;

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    #1 rst = 1'b0;

    // 1: reset then idle
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("t1_ack",   32'(o_ack[0]),  32'd0);
    chk("t1_busy",  32'(o_busy[0]), 32'd0);
    chk("t1_rdata", o_rdata[0],     32'd0);

    // 2: write then read, WAIT_CYCLES=2
    txn(0, 1'b1, 10'h005, 32'hDEADBEEF, n, rd, er);
    chk("t2_wr_lat", 32'(n), 32'd3);
    txn(0, 1'b0, 10'h005, 32'h0, n, rd, er);
    chk("t2_rd_lat",  32'(n), 32'd3);
    chk("t2_rd_data", rd,     32'hDEADBEEF);

    // 3: zero wait, back-to-back reads with req held
    txn(1, 1'b1, 10'h007, 32'hCAFEF00D, n, rd, er);
    chk("t3_wr_lat", 32'(n), 32'd1);
    txn(1, 1'b1, 10'h008, 32'h01234567, n, rd, er);
    drive(1, 1'b1, 1'b0, 10'h007, 32'h0);
    tick();
    chk("t3_acc_busy", 32'(o_busy[1]), 32'd1);
    chk("t3_acc_ack",  32'(o_ack[1]),  32'd0);
    tick();
    chk("t3_ack1",   32'(o_ack[1]), 32'd1);
    chk("t3_rdata1", o_rdata[1],    32'hCAFEF00D);
    drive(1, 1'b1, 1'b0, 10'h008, 32'h0);
    tick();
    chk("t3_gap_ack",  32'(o_ack[1]),  32'd0);
    chk("t3_gap_busy", 32'(o_busy[1]), 32'd1);
    tick();
    chk("t3_ack2",   32'(o_ack[1]), 32'd1);
    chk("t3_rdata2", o_rdata[1],    32'h01234567);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("t3_end_ack",  32'(o_ack[1]),  32'd0);
    chk("t3_end_busy", 32'(o_busy[1]), 32'd0);

    // 4: inputs ignored while waiting
    drive(0, 1'b1, 1'b0, 10'h005, 32'h0);
    tick();
    drive(0, 1'b0, 1'b1, 10'h010, 32'h55555555);
    tick();
    drive(0, 1'b1, 1'b1, 10'h011, 32'h66666666);
    tick();
    drive(0, 1'b0, 1'b0, 10'h012, 32'h0);
    tick();
    chk("t4_ack",   32'(o_ack[0]), 32'd1);
    chk("t4_rdata", o_rdata[0],    32'hDEADBEEF);
    repeat (4) tick();
    chk("t4_no_extra_ack", 32'(o_ack[0]),  32'd0);
    chk("t4_idle_busy",    32'(o_busy[0]), 32'd0);

    // 5: reset during a write's wait phase
    txn(0, 1'b1, 10'h020, 32'h0BADF00D, n, rd, er);
    chk("t5_pre_lat", 32'(n), 32'd3);
    drive(0, 1'b1, 1'b1, 10'h020, 32'h12345678);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(o_busy[0]), 32'd0);
    chk("t5_rst_ack",  32'(o_ack[0]),  32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t5_no_ack", 32'(o_ack[0]), 32'd0);
    txn(0, 1'b0, 10'h020, 32'h0, n, rd, er);
    chk("t5_rd_lat",  32'(n), 32'd3);
    chk("t5_rd_data", rd,     32'h0BADF00D);

    // 6: out-of-range on the 512-word instance, no aliasing onto 0x1FF
    txn(0, 1'b1, 10'h1FF, 32'h11112222, n, rd, er);
`ifdef MEM_RANGE_ERR_EN
    chk("t6_in_wr_err", 32'(er), 32'd0);
`endif
    txn(0, 1'b1, 10'h3FF, 32'hA5A5A5A5, n, rd, er);
    chk("t6_oor_wr_lat", 32'(n), 32'd3);
`ifdef MEM_RANGE_ERR_EN
    chk("t6_oor_wr_err", 32'(er), 32'd1);
`endif
    txn(0, 1'b0, 10'h3FF, 32'h0, n, rd, er);
    chk("t6_oor_rd_lat",  32'(n), 32'd3);
    chk("t6_oor_rd_data", rd,     32'd0);
`ifdef MEM_RANGE_ERR_EN
    chk("t6_oor_rd_err", 32'(er), 32'd1);
`endif
    txn(0, 1'b0, 10'h1FF, 32'h0, n, rd, er);
    chk("t6_alias_data", rd, 32'h11112222);
`ifdef MEM_RANGE_ERR_EN
    chk("t6_in_rd_err", 32'(er), 32'd0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
